centroid_tracker: RTL and testbench

- Multi-channel colour-blob centroid engine for the camera pipeline. It sits after the per-colour binarisation stage and feeds the tracking/servo logic.
- Per frame, it accumulates x/y coordinate sums and pixel counts for each of NUM_CH binary masks.
- At the frame boundary it snapshots the totals and computes per-channel mean x and mean y with one shared sequential divider.
- It publishes the results with a valid pulse and a found flag per channel.

---
 rtl/centroid_tracker.sv | 184 ++++++++++++++++++
 tb/tb_centroid_tracker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_tracker.sv
// Per-channel blob centroid engine: accumulates coordinate sums per frame,
// then divides them by pixel counts with one shared restoring divider.
module centroid_tracker #(
   parameter int NUM_CH     = 2,
   parameter int COORD_W    = 16,
   parameter int CNT_W      = 24,
   parameter int ACC_W      = 40,
   parameter int MIN_PIXELS = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      new_frame,
   input  logic                      pixel_valid,
   input  logic [COORD_W-1:0]        x_pos,
   input  logic [COORD_W-1:0]        y_pos,
   input  logic [NUM_CH-1:0]         mask,
   output logic [NUM_CH*COORD_W-1:0] center_x,
   output logic [NUM_CH*COORD_W-1:0] center_y,
   output logic [NUM_CH-1:0]         found,
   output logic                      result_valid,
   output logic                      busy,
   output logic                      overrun
);

   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int JW  = CHW + 1;
   localparam int BW  = $clog2(ACC_W + 1);
   localparam logic [JW-1:0]    LAST_JOB = JW'(2 * NUM_CH - 1);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
   localparam logic [BW-1:0]    DIV_LAST = BW'(ACC_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DIV, S_STORE, S_DONE
   } state_t;

   state_t r_state;

   logic                r_nf_q;
   logic                w_fb;
   logic [NUM_CH-1:0]   w_hit;
   logic [CNT_W-1:0]    r_cnt    [NUM_CH];
   logic [ACC_W-1:0]    r_xacc   [NUM_CH];
   logic [ACC_W-1:0]    r_yacc   [NUM_CH];
   logic [CNT_W-1:0]    r_snap_c [NUM_CH];
   logic [ACC_W-1:0]    r_snap_x [NUM_CH];
   logic [ACC_W-1:0]    r_snap_y [NUM_CH];
   logic [COORD_W-1:0]  r_stg_x  [NUM_CH];
   logic [COORD_W-1:0]  r_stg_y  [NUM_CH];

   logic [JW-1:0]       r_job;
   logic [BW-1:0]       r_bit;
   logic [ACC_W-1:0]    r_rem;
   logic [ACC_W-1:0]    r_quo;
   logic [ACC_W-1:0]    r_dvs;

   logic [CHW-1:0]      w_ch;
   logic [ACC_W-1:0]    w_sel_sum;
   logic [CNT_W-1:0]    w_sel_cnt;
   logic                w_skip;
   logic [ACC_W:0]      w_rem_sh;
   logic [ACC_W:0]      w_rem_sub;
   logic                w_ge;

   assign w_fb  = new_frame & ~r_nf_q;
   assign w_hit = mask & {NUM_CH{pixel_valid}};

   assign w_ch      = r_job[JW-1:1];
   assign w_sel_sum = r_job[0] ? r_snap_y[w_ch] : r_snap_x[w_ch];
   assign w_sel_cnt = r_snap_c[w_ch];
   assign w_skip    = (w_sel_cnt < MIN_CNT);

   // Dividend shifts out of r_quo's MSB while quotient bits shift in.
   assign w_rem_sh  = {r_rem, r_quo[ACC_W-1]};
   assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};
   assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nf_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_cnt[k]    <= '0;
            r_xacc[k]   <= '0;
            r_yacc[k]   <= '0;
            r_snap_c[k] <= '0;
            r_snap_x[k] <= '0;
            r_snap_y[k] <= '0;
         end
      end else begin
         r_nf_q <= new_frame;
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_fb) begin
               r_cnt[k]  <= w_hit[k] ? CNT_W'(1) : '0;
               r_xacc[k] <= w_hit[k] ? ACC_W'(x_pos) : '0;
               r_yacc[k] <= w_hit[k] ? ACC_W'(y_pos) : '0;
            end else if (w_hit[k] && !(&r_cnt[k])) begin
               r_cnt[k]  <= r_cnt[k] + CNT_W'(1);
               r_xacc[k] <= r_xacc[k] + ACC_W'(x_pos);
               r_yacc[k] <= r_yacc[k] + ACC_W'(y_pos);
            end
            if (w_fb && r_state == S_IDLE) begin
               r_snap_c[k] <= r_cnt[k];
               r_snap_x[k] <= r_xacc[k];
               r_snap_y[k] <= r_yacc[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_job        <= '0;
         r_bit        <= '0;
         r_rem        <= '0;
         r_quo        <= '0;
         r_dvs        <= '0;
         center_x     <= '0;
         center_y     <= '0;
         found        <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_stg_x[k] <= '0;
            r_stg_y[k] <= '0;
         end
      end else begin
         result_valid <= 1'b0;
         overrun      <= w_fb && (r_state != S_IDLE);
         unique case (r_state)
            S_IDLE: begin
               if (w_fb) begin
                  r_state <= S_LOAD;
                  r_job   <= '0;
                  busy    <= 1'b1;
               end
            end
            S_LOAD: begin
               r_dvs <= ACC_W'(w_sel_cnt);
               r_rem <= '0;
               r_bit <= '0;
               if (w_skip) begin
                  r_quo   <= '0;
                  r_state <= S_STORE;
               end else begin
                  r_quo   <= w_sel_sum;
                  r_state <= S_DIV;
               end
            end
            S_DIV: begin
               r_rem <= w_ge ? w_rem_sub[ACC_W-1:0] : w_rem_sh[ACC_W-1:0];
               r_quo <= {r_quo[ACC_W-2:0], w_ge};
               r_bit <= r_bit + BW'(1);
               if (r_bit == DIV_LAST)
                  r_state <= S_STORE;
            end
            S_STORE: begin
               if (r_job[0])
                  r_stg_y[w_ch] <= r_quo[COORD_W-1:0];
               else
                  r_stg_x[w_ch] <= r_quo[COORD_W-1:0];
               if (r_job == LAST_JOB) begin
                  r_state <= S_DONE;
               end else begin
                  r_job   <= r_job + JW'(1);
                  r_state <= S_LOAD;
               end
            end
            S_DONE: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  center_x[k*COORD_W +: COORD_W] <= r_stg_x[k];
                  center_y[k*COORD_W +: COORD_W] <= r_stg_y[k];
                  found[k] <= (r_snap_c[k] >= MIN_CNT);
               end
               result_valid <= 1'b1;
               busy         <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench: instance A (MIN_PIXELS=2) and instance B (CNT_W=4,
// MIN_PIXELS=1) share stimulus; each step checks hand-computed results.
module tb_centroid_tracker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        new_frame = 1'b0;
   logic        pixel_valid = 1'b0;
   logic [15:0] x_pos = '0;
   logic [15:0] y_pos = '0;
   logic [1:0]  mask = '0;

   logic [31:0] a_cx, a_cy, b_cx, b_cy;
   logic [1:0]  a_found, b_found;
   logic        a_rv, a_busy, a_ovr;
   logic        b_rv, b_busy, b_ovr;

   int errors = 0;
   int checks = 0;
   int n;
   int cnt_rv;

   always #5 clk = ~clk;

   centroid_tracker #(
      .NUM_CH(2), .COORD_W(16), .CNT_W(24), .ACC_W(40), .MIN_PIXELS(2)
   ) u_a (
      .clk(clk), .rst(rst), .new_frame(new_frame),
      .pixel_valid(pixel_valid), .x_pos(x_pos), .y_pos(y_pos),
      .mask(mask), .center_x(a_cx), .center_y(a_cy), .found(a_found),
      .result_valid(a_rv), .busy(a_busy), .overrun(a_ovr)
   );

   centroid_tracker #(
      .NUM_CH(2), .COORD_W(16), .CNT_W(4), .ACC_W(40), .MIN_PIXELS(1)
   ) u_b (
      .clk(clk), .rst(rst), .new_frame(new_frame),
      .pixel_valid(pixel_valid), .x_pos(x_pos), .y_pos(y_pos),
      .mask(mask), .center_x(b_cx), .center_y(b_cy), .found(b_found),
      .result_valid(b_rv), .busy(b_busy), .overrun(b_ovr)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input int x, input int y, input logic [1:0] m);
      pixel_valid = 1'b1;
      x_pos = 16'(x);
      y_pos = 16'(y);
      mask = m;
      tick();
      pixel_valid = 1'b0;
      mask = '0;
   endtask

   task automatic fb(input bit v, input int x, input int y,
                     input logic [1:0] m);
      new_frame = 1'b1;
      pixel_valid = v;
      x_pos = 16'(x);
      y_pos = 16'(y);
      mask = m;
      tick();
      new_frame = 1'b0;
      pixel_valid = 1'b0;
      mask = '0;
   endtask

   // Called in the cycle after the fb cycle; n is cycles since fb.
   task automatic wait_rv(input bit sel, output int cyc);
      cyc = 1;
      while (!(sel ? b_rv : a_rv) && cyc < 400) begin
         tick();
         cyc++;
      end
      chk(sel ? "b_rv_timeout" : "a_rv_timeout",
          64'(sel ? b_rv : a_rv), 64'd1);
   endtask

   initial begin
      #1;
      chk("rst_a_cx", 64'(a_cx), 64'd0);
      chk("rst_a_cy", 64'(a_cy), 64'd0);
      chk("rst_a_found", 64'(a_found), 64'd0);
      chk("rst_a_ctl", 64'({a_rv, a_busy, a_ovr}), 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // Frame 1: ch0 three hits, ch1 none.
      pix(10, 20, 2'b01);
      pix(12, 24, 2'b01);
      pix(14, 26, 2'b01);
      fb(0, 0, 0, 2'b00);
      chk("busy_after_fb", 64'(a_busy), 64'd1);
      wait_rv(0, n);
      chk("lat_one_skip", 64'(n), 64'd90);
      chk("f1_cx0", 64'(a_cx[15:0]), 64'd12);
      chk("f1_cy0", 64'(a_cy[15:0]), 64'd23);
      chk("f1_c1", 64'({a_cx[31:16], a_cy[31:16]}), 64'd0);
      chk("f1_found", 64'(a_found), 64'd1);
      chk("f1_b_cx0", 64'(b_cx[15:0]), 64'd12);
      tick();
      chk("rv_one_pulse", 64'(a_rv), 64'd0);
      chk("busy_clear", 64'(a_busy), 64'd0);

      // ch1 with one hit: below A threshold, found in B.
      pix(3, 9, 2'b10);
      fb(0, 0, 0, 2'b00);
      wait_rv(0, n);
      chk("lat_all_skip", 64'(n), 64'd10);
      chk("f2_a_found", 64'(a_found), 64'd0);
      chk("f2_a_cx", 64'(a_cx), 64'd0);
      wait_rv(1, n);
      chk("f2_b_found", 64'(b_found), 64'd2);
      chk("f2_b_cx1", 64'(b_cx[31:16]), 64'd3);
      chk("f2_b_cy1", 64'(b_cy[31:16]), 64'd9);
      tick();

      // ch1 with two hits, floor mean.
      pix(3, 4, 2'b10);
      pix(4, 6, 2'b10);
      fb(0, 0, 0, 2'b00);
      wait_rv(0, n);
      chk("f3_found", 64'(a_found), 64'd2);
      chk("f3_cx1", 64'(a_cx[31:16]), 64'd3);
      chk("f3_cy1", 64'(a_cy[31:16]), 64'd5);
      tick();

      // Overrun: second fb 10 cycles after first.
      pix(10, 20, 2'b01);
      pix(12, 24, 2'b01);
      fb(0, 0, 0, 2'b00);
      repeat (4) tick();
      pix(50, 50, 2'b01);
      repeat (4) tick();
      fb(1, 7, 8, 2'b10);
      chk("ovr_pulse", 64'(a_ovr), 64'd1);
      chk("ovr_pulse_b", 64'(b_ovr), 64'd1);
      chk("ovr_still_busy", 64'(a_busy), 64'd1);
      tick();
      chk("ovr_one_cycle", 64'(a_ovr), 64'd0);
      wait_rv(0, n);
      chk("ovr_lat", 64'(n), 64'd79);
      chk("ovr_cx0", 64'(a_cx[15:0]), 64'd11);
      chk("ovr_cy0", 64'(a_cy[15:0]), 64'd22);
      chk("ovr_found", 64'(a_found), 64'd1);
      tick();
      pix(9, 10, 2'b10);
      fb(0, 0, 0, 2'b00);
      wait_rv(0, n);
      chk("restart_found", 64'(a_found), 64'd2);
      chk("restart_cx1", 64'(a_cx[31:16]), 64'd8);
      chk("restart_cy1", 64'(a_cy[31:16]), 64'd9);
      chk("restart_c0", 64'({a_cx[15:0], a_cy[15:0]}), 64'd0);
      tick();

      // Pixel in the fb cycle is the first pixel of the new frame.
      fb(1, 100, 50, 2'b01);
      wait_rv(1, n);
      tick();
      fb(0, 0, 0, 2'b00);
      wait_rv(1, n);
      chk("fbpix_b_cx0", 64'(b_cx[15:0]), 64'd100);
      chk("fbpix_b_cy0", 64'(b_cy[15:0]), 64'd50);
      chk("fbpix_b_found", 64'(b_found), 64'd1);
      chk("fbpix_a_found", 64'(a_found), 64'd0);
      tick();

      // Reset in the middle of a divide.
      pix(10, 20, 2'b01);
      pix(10, 20, 2'b01);
      fb(0, 0, 0, 2'b00);
      repeat (20) tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_b_cx", 64'(b_cx), 64'd0);
      chk("mid_rst_b_cy", 64'(b_cy), 64'd0);
      chk("mid_rst_b_found", 64'(b_found), 64'd0);
      chk("mid_rst_busy", 64'({a_busy, b_busy}), 64'd0);
      repeat (3) tick();
      rst = 1'b1;
      cnt_rv = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (a_rv || b_rv) cnt_rv++;
      end
      chk("mid_rst_no_rv", 64'(cnt_rv), 64'd0);
      pix(6, 8, 2'b01);
      pix(8, 12, 2'b01);
      fb(0, 0, 0, 2'b00);
      wait_rv(0, n);
      chk("post_rst_lat", 64'(n), 64'd90);
      chk("post_rst_cx0", 64'(a_cx[15:0]), 64'd7);
      chk("post_rst_cy0", 64'(a_cy[15:0]), 64'd10);
      chk("post_rst_found", 64'(a_found), 64'd1);
      tick();

      // Saturation: B freezes ch1 at 15 pixels.
      for (int i = 0; i < 20; i++) pix(5, 3, 2'b10);
      fb(0, 0, 0, 2'b00);
      wait_rv(1, n);
      chk("sat_b_cx1", 64'(b_cx[31:16]), 64'd5);
      chk("sat_b_cy1", 64'(b_cy[31:16]), 64'd3);
      chk("sat_b_found", 64'(b_found), 64'd2);
      chk("sat_a_cx1", 64'(a_cx[31:16]), 64'd5);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
